// File: rtl/uart_cmd_parser.sv
// ASCII command parser: S/L/B commands terminated by CR drive seg/led/beep and answer K or E.
// Optional macro CMD_ECHO_EN echoes every accepted rx byte back through the TX queue.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned TXQ_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] seg_val,
  output logic [4:0]  led_val,
  output logic        beep_en,
  output logic        cmd_err
);

  localparam int unsigned AW = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_B  = 8'h42;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;

  typedef enum logic [2:0] {IDLE, ARG, WAIT_CR, RESP, DISCARD} state_t;
  typedef enum logic [1:0] {CMD_S, CMD_L, CMD_B} cmd_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [2:0]    dig_q, dig_d;
  logic [15:0]   acc_q, acc_d;
  logic          resp_k_q, resp_k_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [15:0]   seg_q, seg_d;
  logic [4:0]    led_q, led_d;
  logic          beep_q, beep_d;

  logic [7:0]    txq_q [TXQ_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] q_cnt_q, q_cnt_d;
  logic          tx_valid_q;
  logic          q_full_c, push_c, pop_c, resp_push_c;
  logic [7:0]    push_data_c;

  logic          dig_ok_c, arg_ok_c, timed_c, expire_c;
  logic [3:0]    nib_c;

  // Hex digit decode of the incoming byte; B accepts only '0'/'1'
  always_comb begin
    dig_ok_c = 1'b0;
    nib_c    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      dig_ok_c = 1'b1;
      nib_c    = rx_data[3:0];
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      dig_ok_c = 1'b1;
      nib_c    = 4'(rx_data - 8'h37);
    end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      dig_ok_c = 1'b1;
      nib_c    = 4'(rx_data - 8'h57);
    end
    arg_ok_c = dig_ok_c && ((cmd_q != CMD_B) || (rx_data[7:1] == 7'b0011000));
  end

  assign q_full_c    = (q_cnt_q == CW'(TXQ_DEPTH));
  assign resp_push_c = (state_q == RESP) && !q_full_c;
  assign timed_c     = (state_q == ARG) || (state_q == WAIT_CR) || (state_q == DISCARD);

  // Next-state, accumulator, timeout and target-output logic
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    dig_d    = dig_q;
    acc_d    = acc_q;
    resp_k_d = resp_k_q;
    err_d    = 1'b0;
    seg_d    = seg_q;
    led_d    = led_q;
    beep_d   = beep_q;
    tmo_d    = '0;
    expire_c = 1'b0;

    // A byte in the same cycle as expiry wins: the counter only runs on idle cycles
    if (timed_c && !rx_valid) begin
      tmo_d    = tmo_q + TW'(1);
      expire_c = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    end

    case (state_q)
      IDLE: begin
        if (rx_valid && rx_data != CH_CR && rx_data != CH_LF) begin
          acc_d   = '0;
          state_d = ARG;
          if (rx_data == CH_S) begin
            cmd_d = CMD_S;
            dig_d = 3'd4;
          end else if (rx_data == CH_L) begin
            cmd_d = CMD_L;
            dig_d = 3'd2;
          end else if (rx_data == CH_B) begin
            cmd_d = CMD_B;
            dig_d = 3'd1;
          end else begin
            state_d = DISCARD;
          end
        end
      end
      ARG: begin
        if (rx_valid) begin
          if (rx_data == CH_CR) begin
            err_d    = 1'b1;
            resp_k_d = 1'b0;
            state_d  = RESP;
          end else if (arg_ok_c) begin
            acc_d = {acc_q[11:0], nib_c};
            dig_d = dig_q - 3'd1;
            if (dig_q == 3'd1) state_d = WAIT_CR;
          end else begin
            state_d = DISCARD;
          end
        end else if (expire_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_CR: begin
        if (rx_valid) begin
          if (rx_data == CH_CR) begin
            resp_k_d = 1'b1;
            state_d  = RESP;
          end else begin
            state_d = DISCARD;
          end
        end else if (expire_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        if (rx_valid && rx_data == CH_CR) begin
          err_d    = 1'b1;
          resp_k_d = 1'b0;
          state_d  = RESP;
        end else if (!rx_valid && expire_c) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        if (!q_full_c) begin
          state_d = IDLE;
          if (resp_k_q) begin
            case (cmd_q)
              CMD_S:   seg_d  = acc_q;
              CMD_L:   led_d  = acc_q[4:0];
              default: beep_d = acc_q[0];
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_S;
      dig_q    <= '0;
      acc_q    <= '0;
      resp_k_q <= 1'b0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      seg_q    <= '0;
      led_q    <= '0;
      beep_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      dig_q    <= dig_d;
      acc_q    <= acc_d;
      resp_k_q <= resp_k_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      seg_q    <= seg_d;
      led_q    <= led_d;
      beep_q   <= beep_d;
    end
  end

  // TX queue push source: response in RESP, otherwise the optional echo
  always_comb begin
    push_c      = resp_push_c;
    push_data_c = resp_k_q ? CH_K : CH_E;
`ifdef CMD_ECHO_EN
    if (rx_valid && state_q != RESP && !q_full_c) begin
      push_c      = 1'b1;
      push_data_c = rx_data;
    end
`endif
    pop_c   = tx_valid_q && tx_ready;
    q_cnt_d = q_cnt_q + CW'(push_c) - CW'(pop_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      q_cnt_q    <= '0;
      tx_valid_q <= 1'b0;
      for (int i = 0; i < TXQ_DEPTH; i++) txq_q[i] <= '0;
    end else begin
      if (push_c) begin
        txq_q[wr_ptr_q] <= push_data_c;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      q_cnt_q    <= q_cnt_d;
      tx_valid_q <= (q_cnt_d != '0);
    end
  end

  assign tx_data  = txq_q[rd_ptr_q];
  assign tx_valid = tx_valid_q;
  assign seg_val  = seg_q;
  assign led_val  = led_q;
  assign beep_en  = beep_q;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; expectations follow CMD_ECHO_EN when the macro is defined.
module tb_uart_cmd_parser;

  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;

  logic        clk, rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] seg_val;
  logic [4:0]  led_val;
  logic        beep_en;
  logic        cmd_err;

  uart_cmd_parser #(.TIMEOUT_CYCLES(100), .TXQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .seg_val(seg_val), .led_val(led_val), .beep_en(beep_en), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       cmd;
    logic [15:0] seg;
    logic [4:0]  led;
    logic        beep;
    logic [7:0]  resp;
    int          errs;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         err_cnt = 0;
  int         n_run = 0;
  int         n_fail = 0;

  // Transmitted bytes and cmd_err pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
    if (cmd_err) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    cycles(2);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Expected TX stream: echoed bytes (when enabled) followed by the optional response
  task automatic build_exp(input string s, input bit has_resp, input logic [7:0] resp);
    exp_q.delete();
`ifdef CMD_ECHO_EN
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`endif
    if (has_resp) exp_q.push_back(resp);
  endtask

  task automatic check_stream(input string name, input int base);
    int n;
    n = got_q.size() - base;
    check({name, " tx count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s tx byte %0d", name, i), 32'(got_q[base + i]), 32'(exp_q[i]));
  endtask

  initial begin
    int base, ebase, waited;
    vecs[0]  = '{"L3F\015",           16'h1A2F, 5'h1F, 1'b0, CH_K, 0};
    vecs[1]  = '{"B1\015",            16'h1A2F, 5'h1F, 1'b1, CH_K, 0};
    vecs[2]  = '{"SG\015",            16'h1A2F, 5'h1F, 1'b1, CH_E, 1};
    vecs[3]  = '{"\015\012S0000\015", 16'h0000, 5'h1F, 1'b1, CH_K, 0};
    vecs[4]  = '{"L20\015",           16'h0000, 5'h00, 1'b1, CH_K, 0};
    vecs[5]  = '{"B2\015",            16'h0000, 5'h00, 1'b1, CH_E, 1};
    vecs[6]  = '{"S12\015",           16'h0000, 5'h00, 1'b1, CH_E, 1};
    vecs[7]  = '{"X\015",             16'h0000, 5'h00, 1'b1, CH_E, 1};
    vecs[8]  = '{"L123\015",          16'h0000, 5'h00, 1'b1, CH_E, 1};
    vecs[9]  = '{"b1\015",            16'h0000, 5'h00, 1'b1, CH_E, 1};
    vecs[10] = '{"SdEaD\015",         16'hDEAD, 5'h00, 1'b1, CH_K, 0};
    vecs[11] = '{"Lff\015",           16'hDEAD, 5'h1F, 1'b1, CH_K, 0};
    vecs[12] = '{"B0\015",            16'hDEAD, 5'h1F, 1'b0, CH_K, 0};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset seg_val", 32'(seg_val), 32'h0);
    check("reset led_val", 32'(led_val), 32'h0);
    check("reset beep_en", 32'(beep_en), 32'h0);
    check("reset cmd_err", 32'(cmd_err), 32'h0);
    check("reset tx_valid", 32'(tx_valid), 32'h0);
    rst = 1'b0;
    cycles(2);

    // seg_val updates exactly one cycle after the CR strobe
    base = got_q.size();
    send_str("S1a2F");
    rx_data = 8'h0D; rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("seg before update", 32'(seg_val), 32'h0);
    cycles(1);
    check("seg after CR", 32'(seg_val), 32'h1A2F);
    cycles(20);
    build_exp("S1a2F\015", 1'b1, CH_K);
    check_stream("S1a2F", base);

    for (int i = 0; i < 13; i++) begin
      base  = got_q.size();
      ebase = err_cnt;
      send_str(vecs[i].cmd);
      cycles(20);
      check($sformatf("row%0d seg_val", i), 32'(seg_val), 32'(vecs[i].seg));
      check($sformatf("row%0d led_val", i), 32'(led_val), 32'(vecs[i].led));
      check($sformatf("row%0d beep_en", i), 32'(beep_en), 32'(vecs[i].beep));
      check($sformatf("row%0d cmd_err pulses", i), 32'(err_cnt - ebase), 32'(vecs[i].errs));
      build_exp(vecs[i].cmd, 1'b1, vecs[i].resp);
      check_stream($sformatf("row%0d", i), base);
    end

    // Inter-byte timeout: error pulse, no response, parser back in IDLE
    base  = got_q.size();
    ebase = err_cnt;
    send_str("S12");
    waited = 0;
    while (err_cnt == ebase && waited < 200) begin
      cycles(1);
      waited++;
    end
    check("timeout fired", 32'(err_cnt - ebase), 32'd1);
    check("timeout latency in range", 32'(waited >= 90 && waited <= 110), 32'd1);
    cycles(5);
    check("timeout single pulse", 32'(err_cnt - ebase), 32'd1);
    check("timeout seg unchanged", 32'(seg_val), 32'hDEAD);
    build_exp("S12", 1'b0, 8'h00);
    check_stream("timeout", base);
    base = got_q.size();
    send_str("S0001\015");
    cycles(20);
    check("after timeout seg", 32'(seg_val), 32'h0001);
    build_exp("S0001\015", 1'b1, CH_K);
    check_stream("after timeout", base);

    // Reset in the middle of a command
    send_str("L1");
    cycles(10);
    #2 rst = 1'b1;
    #1;
    check("mid rst seg_val", 32'(seg_val), 32'h0);
    check("mid rst led_val", 32'(led_val), 32'h0);
    check("mid rst beep_en", 32'(beep_en), 32'h0);
    check("mid rst tx_valid", 32'(tx_valid), 32'h0);
    cycles(2);
    rst   = 1'b0;
    base  = got_q.size();
    ebase = err_cnt;
    cycles(30);
    send_byte(8'h0D);
    cycles(10);
    check("post rst errs", 32'(err_cnt - ebase), 32'h0);
    check("post rst led_val", 32'(led_val), 32'h0);
    build_exp("\015", 1'b0, 8'h00);
    check_stream("post rst", base);

    // Stalled transmitter: queue holds bytes in FIFO order and drains once ready
    tx_ready = 1'b0;
    beep_en_preset: begin
      base = got_q.size();
      send_str("B1\015");
      tx_ready = 1'b1;
      cycles(10);
      check("preset beep", 32'(beep_en), 32'h1);
    end
    tx_ready = 1'b0;
    base = got_q.size();
    send_str("B0\015");
    cycles(5);
    build_exp("B0\015", 1'b1, CH_K);
    check("stall tx_valid", 32'(tx_valid), 32'h1);
    check("stall head byte", 32'(tx_data), 32'(exp_q[0]));
    check("stall nothing sent", 32'(got_q.size() - base), 32'h0);
    check("stall beep_en", 32'(beep_en), 32'h0);
    tx_ready = 1'b1;
    cycles(10);
    check_stream("stall drain", base);
    check("drained tx_valid", 32'(tx_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
